// File: rtl/pwm_pkg.sv
// Shared types and widths for the PWM capture block and its divider.
package pwm_pkg;

  localparam int CNT_W  = 16;
  localparam int DUTY_W = 8;
  localparam int DIVN_W = 24;
  localparam int PCT    = 100;

  typedef enum logic [1:0] {
    IDLE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

endpackage

// File: rtl/pwm_div.sv
// Sequential restoring divider: one quotient bit per cycle, Done 24 cycles after Start.
module pwm_div
  import pwm_pkg::*;
(
  input  logic              SysClk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DIVN_W-1:0] Num,
  input  logic [CNT_W-1:0]  Den,
  output logic [DUTY_W-1:0] Quot,
  output logic              Busy,
  output logic              Done
);

  logic [DIVN_W-1:0] acc_reg;
  logic [CNT_W-1:0]  rem_reg;
  logic [CNT_W-1:0]  den_reg;
  logic [4:0]        step_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [CNT_W:0]    rem_shift;
  logic [CNT_W-1:0]  rem_sub;
  logic              fits;

  // The numerator register shifts left and refills with quotient bits.
  assign rem_shift = {rem_reg, acc_reg[DIVN_W-1]};
  assign fits      = rem_shift >= {1'b0, den_reg};
  assign rem_sub   = rem_shift[CNT_W-1:0] - den_reg;

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      acc_reg  <= '0;
      rem_reg  <= '0;
      den_reg  <= '0;
      step_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (Start && !busy_reg) begin
        acc_reg  <= Num;
        rem_reg  <= '0;
        den_reg  <= Den;
        step_reg <= '0;
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        acc_reg  <= {acc_reg[DIVN_W-2:0], fits};
        rem_reg  <= fits ? rem_sub : rem_shift[CNT_W-1:0];
        step_reg <= step_reg + 5'd1;
        if (step_reg == 5'd23) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign Quot = (den_reg == '0) ? '0 : acc_reg[DUTY_W-1:0];
  assign Busy = busy_reg;
  assign Done = done_reg;

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and duty cycle of an asynchronous PWM input,
// flagging a stuck input and measurements lost to a busy divider.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT     = 16'd50000,
  parameter int               SYNC_STAGES = 2
) (
  input  logic              SysClk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              PwmIn,
  output logic [CNT_W-1:0]  Period,
  output logic [CNT_W-1:0]  HighTime,
  output logic [DUTY_W-1:0] DutyCycle,
  output logic              Valid,
  output logic              NoSignal,
  output logic              Overrun
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   edge_reg;
  logic                   pwm_s, rise, fall;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0]       hi_cap_reg, pend_per_reg, pend_hi_reg;
  logic                   launch, cap_hi, timeout, keep_reg;

  logic [DIVN_W-1:0]      div_num;
  logic [DUTY_W-1:0]      div_quot;
  logic                   div_busy, div_done;

  logic [CNT_W-1:0]       period_reg, high_reg;
  logic [DUTY_W-1:0]      duty_reg;
  logic                   valid_reg, nosig_reg, ovr_reg;

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) sync_reg[0] <= 1'b0;
    else        sync_reg[0] <= PwmIn;
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) sync_reg[gi] <= 1'b0;
        else        sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign pwm_s = sync_reg[SYNC_STAGES-1];
  assign rise  = pwm_s & ~edge_reg;
  assign fall  = ~pwm_s & edge_reg;

  // A strobe in the timeout cycle wins over the timeout.
  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    cap_hi     = 1'b0;
    timeout    = 1'b0;
    if (!Enable) begin
      state_next = IDLE;
    end else if (rise) begin
      launch     = (state_reg == MEAS_LOW);
      state_next = MEAS_HIGH;
    end else if (fall && state_reg == MEAS_HIGH) begin
      cap_hi     = 1'b1;
      state_next = MEAS_LOW;
    end else if (!fall && state_reg != IDLE && cnt_reg >= TIMEOUT) begin
      timeout    = 1'b1;
      state_next = IDLE;
    end
  end

  always_comb begin
    cnt_next = cnt_reg + 16'd1;
    if (!Enable)                 cnt_next = '0;
    else if (rise)               cnt_next = 16'd1;
    else if (state_next == IDLE) cnt_next = '0;
  end

  assign div_num = DIVN_W'(hi_cap_reg) * DIVN_W'(PCT);

  pwm_div u_div (
    .SysClk (SysClk),
    .Reset  (Reset),
    .Start  (launch),
    .Num    (div_num),
    .Den    (cnt_reg),
    .Quot   (div_quot),
    .Busy   (div_busy),
    .Done   (div_done)
  );

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      edge_reg     <= 1'b0;
      hi_cap_reg   <= '0;
      pend_per_reg <= '0;
      pend_hi_reg  <= '0;
      keep_reg     <= 1'b0;
      period_reg   <= '0;
      high_reg     <= '0;
      duty_reg     <= '0;
      valid_reg    <= 1'b0;
      nosig_reg    <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      edge_reg  <= pwm_s;
      valid_reg <= 1'b0;
      if (cap_hi) hi_cap_reg <= cnt_reg;
      if (launch && !div_busy) begin
        pend_per_reg <= cnt_reg;
        pend_hi_reg  <= hi_cap_reg;
      end
      if (launch && div_busy) ovr_reg <= 1'b1;
      // A divide started before a disable or timeout must never publish.
      if (!Enable || timeout)       keep_reg <= 1'b0;
      else if (launch && !div_busy) keep_reg <= 1'b1;
      if (timeout) begin
        period_reg <= '0;
        high_reg   <= '0;
        duty_reg   <= pwm_s ? DUTY_W'(PCT) : '0;
        valid_reg  <= 1'b1;
        nosig_reg  <= 1'b1;
      end else if (div_done && keep_reg && Enable) begin
        period_reg <= pend_per_reg;
        high_reg   <= pend_hi_reg;
        duty_reg   <= div_quot;
        valid_reg  <= 1'b1;
      end
      if (Enable && rise) nosig_reg <= 1'b0;
    end
  end

  assign Period    = period_reg;
  assign HighTime  = high_reg;
  assign DutyCycle = duty_reg;
  assign Valid     = valid_reg;
  assign NoSignal  = nosig_reg;
  assign Overrun   = ovr_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised and directed bench for pwm_capture against an event-level model.
module tb_pwm_capture;

  localparam logic [15:0] TMO = 16'd4000;
  localparam int LAT  = 28;   // pin edge set at a negedge -> Valid seen at a negedge
  localparam int DIVC = 25;   // divider occupancy, launch to result

  logic        SysClk = 1'b0;
  logic        Reset  = 1'b0;
  logic        Enable = 1'b0;
  logic        PwmIn  = 1'b0;
  logic [15:0] Period, HighTime;
  logic [7:0]  DutyCycle;
  logic        Valid, NoSignal, Overrun;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  pwm_capture #(.TIMEOUT(TMO), .SYNC_STAGES(2)) dut (
    .SysClk    (SysClk),
    .Reset     (Reset),
    .Enable    (Enable),
    .PwmIn     (PwmIn),
    .Period    (Period),
    .HighTime  (HighTime),
    .DutyCycle (DutyCycle),
    .Valid     (Valid),
    .NoSignal  (NoSignal),
    .Overrun   (Overrun)
  );

  always #5 SysClk = ~SysClk;

  // Event-level model: pin history gives strobe times, measurements are differences of strobe times.
  bit h1, h2, h3;
  bit armed, have_fall, pend_v;
  int last_rise, fall_t, last_start, pend_done, pend_per, pend_hi;
  int e_per, e_hi, e_duty;
  bit e_valid, e_nosig, e_ovr;

  always @(posedge SysClk) begin
    bit r, f, tmo;
    cyc++;
    if (!Reset) begin
      h1 = 0; h2 = 0; h3 = 0;
      armed = 0; have_fall = 0; pend_v = 0;
      last_rise = 0; fall_t = 0; last_start = -1000;
      e_per = 0; e_hi = 0; e_duty = 0; e_valid = 0; e_nosig = 0; e_ovr = 0;
    end else begin
      r   = h2 && !h3;
      f   = !h2 && h3;
      tmo = Enable && armed && !r && !f && ((cyc - last_rise) >= int'(TMO));
      e_valid = 0;
      if (tmo) begin
        e_per = 0; e_hi = 0; e_duty = h2 ? 100 : 0;
        e_valid = 1; e_nosig = 1; pend_v = 0;
      end else if (pend_v && pend_done == cyc) begin
        if (Enable) begin
          e_per = pend_per; e_hi = pend_hi; e_duty = (pend_hi * 100) / pend_per;
          e_valid = 1;
        end
        pend_v = 0;
      end
      if (!Enable) begin
        armed = 0; have_fall = 0; pend_v = 0;
      end else if (r) begin
        if (armed && have_fall) begin
          if (cyc - last_start >= DIVC) begin
            last_start = cyc;
            pend_v = 1; pend_done = cyc + DIVC;
            pend_per = cyc - last_rise; pend_hi = fall_t - last_rise;
          end else begin
            e_ovr = 1;
          end
        end
        armed = 1; have_fall = 0; last_rise = cyc; e_nosig = 0;
      end else if (f && armed && !have_fall) begin
        have_fall = 1; fall_t = cyc;
      end else if (tmo) begin
        armed = 0; have_fall = 0;
      end
      h3 = h2; h2 = h1; h1 = PwmIn;
    end
  end

  int vcount = 0;
  int lv_per, lv_hi, lv_duty, lv_cyc;

  // Per-cycle compare of every output against the model (zeros while in reset).
  always @(negedge SysClk) begin
    int wp, wh, wd;
    bit wv, wn, wo;
    if (!Reset) begin
      wp = 0; wh = 0; wd = 0; wv = 0; wn = 0; wo = 0;
    end else begin
      wp = e_per; wh = e_hi; wd = e_duty; wv = e_valid; wn = e_nosig; wo = e_ovr;
    end
    n_cmp++;
    if (Period !== 16'(wp) || HighTime !== 16'(wh) || DutyCycle !== 8'(wd) ||
        Valid !== wv || NoSignal !== wn || Overrun !== wo) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL cycle_check cyc=%0d got per=%0d hi=%0d duty=%0d v=%0b ns=%0b ov=%0b want per=%0d hi=%0d duty=%0d v=%0b ns=%0b ov=%0b",
                 cyc, Period, HighTime, DutyCycle, Valid, NoSignal, Overrun, wp, wh, wd, wv, wn, wo);
    end
    if (Valid === 1'b1) begin
      vcount++;
      lv_per = int'(Period); lv_hi = int'(HighTime); lv_duty = int'(DutyCycle); lv_cyc = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge SysClk);
  endtask

  int rise_cyc;

  task automatic pulse(input int per, input int hi);
    PwmIn = 1'b1;
    rise_cyc = cyc;
    cycles(hi);
    PwmIn = 1'b0;
    cycles(per - hi);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, int'(Period), 0);
    check({tag, "_high"},   int'(HighTime), 0);
    check({tag, "_duty"},   int'(DutyCycle), 0);
    check({tag, "_valid"},  int'(Valid), 0);
    check({tag, "_nosig"},  int'(NoSignal), 0);
    check({tag, "_ovr"},    int'(Overrun), 0);
  endtask

  initial begin
    int v0, p, h;
    cycles(3);
    check_zero("reset");
    Reset = 1'b1;
    cycles(2);
    Enable = 1'b1;
    cycles(5);

    // steady 1000/250
    v0 = vcount;
    repeat (4) pulse(1000, 250);
    cycles(30);
    check("steady_count", vcount - v0, 3);
    check("steady_period", lv_per, 1000);
    check("steady_high", lv_hi, 250);
    check("steady_duty", lv_duty, 25);
    check("steady_latency", lv_cyc - rise_cyc, LAT);

    // duty floor and minimum high time
    repeat (2) pulse(1000, 999);
    cycles(30);
    check("hi999_period", lv_per, 1000);
    check("hi999_duty", lv_duty, 99);
    repeat (2) pulse(1000, 1);
    cycles(30);
    check("hi1_high", lv_hi, 1);
    check("hi1_duty", lv_duty, 0);

    // random waveforms slower than the divider
    repeat (25) begin
      p = $urandom_range(700, 30);
      h = $urandom_range(p - 1, 1);
      pulse(p, h);
    end

    // stuck high -> timeout
    cycles(10);
    PwmIn = 1'b1;
    rise_cyc = cyc;
    v0 = vcount;
    cycles(int'(TMO) + 100);
    check("tmo_count", vcount - v0, 2);
    check("tmo_latency", lv_cyc - rise_cyc, int'(TMO) + 3);
    check("tmo_period", lv_per, 0);
    check("tmo_duty", lv_duty, 100);
    check("tmo_nosig", int'(NoSignal), 1);
    check("tmo_ovr", int'(Overrun), 0);
    PwmIn = 1'b0;
    cycles(20);
    check("tmo_nosig_hold", int'(NoSignal), 1);
    PwmIn = 1'b1;
    cycles(10);
    check("tmo_nosig_clear", int'(NoSignal), 0);
    cycles(10);
    PwmIn = 1'b0;
    cycles(50);

    // faster than the divider -> overrun
    repeat (10) pulse(20, 10);
    cycles(40);
    check("fast_ovr", int'(Overrun), 1);
    check("fast_period", lv_per, 20);
    check("fast_duty", lv_duty, 50);
    cycles(50);
    check("ovr_sticky", int'(Overrun), 1);

    // asynchronous reset mid-divide
    pulse(1000, 250);
    PwmIn = 1'b1;
    cycles(10);
    v0 = vcount;
    @(posedge SysClk);
    #2 Reset = 1'b0;
    #1 check_zero("async_rst");
    cycles(3);
    PwmIn = 1'b0;
    Reset = 1'b1;
    cycles(100);
    check("rst_no_valid", vcount - v0, 0);
    v0 = vcount;
    pulse(1000, 250);
    pulse(1000, 250);
    check("rst_first_count", vcount - v0, 1);
    check("rst_first_latency", lv_cyc - rise_cyc, LAT);
    check("rst_first_period", lv_per, 1000);

    // Enable dropped during the low phase
    pulse(1000, 250);
    PwmIn = 1'b1;
    cycles(250);
    PwmIn = 1'b0;
    cycles(100);
    v0 = vcount;
    Enable = 1'b0;
    cycles(300);
    check("dis_no_valid", vcount - v0, 0);
    check("dis_hold_period", int'(Period), 1000);
    check("dis_hold_duty", int'(DutyCycle), 25);
    Enable = 1'b1;
    cycles(350);
    pulse(1000, 250);
    pulse(1000, 250);
    cycles(30);
    check("reen_count", vcount - v0, 1);
    check("reen_period", lv_per, 1000);
    check("reen_duty", lv_duty, 25);

    // short disable while a divide is in flight
    PwmIn = 1'b1;
    cycles(10);
    v0 = vcount;
    Enable = 1'b0;
    cycles(5);
    Enable = 1'b1;
    cycles(40);
    check("abort_no_valid", vcount - v0, 0);
    PwmIn = 1'b0;
    cycles(300);

    // random fast waveforms with random disables
    repeat (60) begin
      p = $urandom_range(80, 4);
      h = $urandom_range(p - 1, 1);
      if ($urandom_range(9, 0) == 0) begin
        Enable = 1'b0;
        cycles($urandom_range(40, 1));
        Enable = 1'b1;
      end
      pulse(p, h);
    end
    cycles(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    n_fail++;
    $display("FAIL watchdog: got cyc=%0d want completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Receive-side counterpart of the PWM generator. It samples an external PWM waveform on one clock and measures the period and high time in SysClk cycles. It also derives the integer duty-cycle percentage and flags a missing or stuck input. It sits on the input side of the design and feeds the control logic that consumes Period/DutyCycle-style values.

Parameters:
TIMEOUT, 16'd50000, idle cycles without a detected edge before NoSignal asserts; legal range 2..65534
SYNC_STAGES, 2, input synchronizer depth; legal range 2..3

Ports:
SysClk  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-low reset
Enable  input  1  1 = measure; 0 = return to IDLE and hold outputs
PwmIn  input  1  asynchronous PWM waveform under measurement
Period  output  16  last measured period, SysClk cycles
HighTime  output  16  last measured high time, SysClk cycles
DutyCycle  output  8  floor(HighTime*100/Period), 0..100
Valid  output  1  one-cycle strobe when Period/HighTime/DutyCycle update
NoSignal  output  1  level; 1 while the input is stuck/absent
Overrun  output  1  sticky; a measurement was dropped because the divider was busy

Behaviour:
- Reset (Reset=0, asynchronous): all outputs 0, FSM=IDLE, counter=0, synchronizer flops=0, divider idle.
- Input path: PwmIn passes through SYNC_STAGES flops, then one edge-detect flop. The rise/fall strobe occurs SYNC_STAGES+1 cycles after the pin transition. Every measurement is in strobe-to-strobe cycles.
- Counter: 16 bits. Loaded with 1 on each rise strobe; otherwise increments each cycle. Because TIMEOUT < 65535, the counter never wraps.
- FSM states: IDLE, MEAS_HIGH, MEAS_LOW.
  - IDLE: the first rise strobe loads the counter and moves to MEAS_HIGH. No result is produced yet.
  - MEAS_HIGH: a fall strobe latches hi_cap=counter and moves to MEAS_LOW.
  - MEAS_LOW: a rise strobe latches per_cap=counter, launches the divider with (hi_cap*100, per_cap), reloads the counter and moves to MEAS_HIGH.
  - Any state except IDLE: counter==TIMEOUT moves to IDLE.
- Example: rise strobes at cycles 10 and 1010 give Period=1000.
- Divider: numerator is 24 bits (hi_cap*100 ≤ 6,553,400), denominator is 16 bits. Restoring, one quotient bit per cycle, 24 cycles from start to done.
  - On done: Period, HighTime and DutyCycle update together and Valid=1 for exactly one cycle.
  - Latency from the closing rise strobe to Valid is 25 cycles.
- Divider busy at launch: the new measurement is discarded, Overrun is set sticky, outputs are unchanged and the FSM still advances. Overrun clears only on Reset.
- Timeout, i.e. no strobe for TIMEOUT cycles:
  - FSM moves to IDLE, NoSignal=1, Period=0 and HighTime=0.
  - DutyCycle=100 if the synchronized input is 1, otherwise 0. Valid pulses once.
  - NoSignal clears on the next rise strobe.
- Simultaneous timeout and strobe in the same cycle: the strobe wins, there is no timeout and normal transitions apply.
- Enable=0:
  - FSM moves to IDLE and the counter goes to 0.
  - An in-flight divide is aborted with no Valid.
  - Outputs hold their last values and NoSignal holds.
  - Measurement restarts at the first rise strobe after Enable=1.
- Reset mid-operation: immediate return to reset values, including an in-flight divide.
- A glitch shorter than one SysClk period may be missed. A glitch that is caught is measured literally; no filtering is applied.

Decomposition:
- Package pwm_pkg holds:
  - FSM state encoding (IDLE/MEAS_HIGH/MEAS_LOW)
  - widths CNT_W=16, DUTY_W=8, DIVN_W=24
  - constant PCT=100
- Sub-module pwm_div: sequential restoring divider.
  - Ports: SysClk, Reset, Start, Num[23:0], Den[15:0], Quot[7:0], Busy, Done.
  - Den=0 gives Quot=0; this is unreachable because Period ≥ 2.

Test Plan:
- Steady 1000-cycle period, 250 high, Enable=1, TIMEOUT=50000 -> from the 2nd period on, Valid every 1000 cycles; Period=1000, HighTime=250, DutyCycle=25.
- Period 1000, high 999 -> DutyCycle=99 (floor, not rounded); high 1 -> DutyCycle=0, HighTime=1.
- PwmIn held 1 after a valid measurement, TIMEOUT=4000 -> Valid once ~4000 cycles after the last rise strobe; NoSignal=1, Period=0, DutyCycle=100. A following rise strobe clears NoSignal.
- Period 20, high 10 (faster than the 25-cycle divider) -> Overrun=1 by the second launch. Results still appear at the divider rate with correct value 50; Overrun stays 1 until Reset.
- Reset driven low mid-divide, asynchronous to SysClk -> all outputs 0 immediately, no Valid. After release the first result appears only after two rise strobes plus 25 cycles.
- Enable dropped during MEAS_LOW for 300 cycles, then re-raised -> no Valid during the gap, outputs hold the prior values (Period=1000, DutyCycle=25), and a fresh correct result follows after a full period.
